// File: rtl/arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | arb_pkg: shared FSM encoding, sizing and round-robin pick helper   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package arb_pkg;

    localparam int c_cnt_w        = 4;
    localparam int c_max_hold_def = 8;

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_grant = 1'b1;

    // Returns {found, index}: first set request searching upward from last+1 with wrap.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | decoder: 2-to-4 one-hot decoder with enable                        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module decoder (
    input  logic [1:0] i_sel,
    input  logic       i_en,
    output logic [3:0] o_dec
);

    always_comb begin
        o_dec = 4'b0000;
        if (i_en) begin
            o_dec = 4'b0001 << i_sel;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rr_arbiter4.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_arbiter4: 4-way round-robin arbiter with hold limit and bubble  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module rr_arbiter4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = c_max_hold_def
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic       gnt_valid,
    output logic [1:0] gnt_id,
    output logic       timeout
);

    localparam logic [c_cnt_w-1:0] c_hold_last = c_cnt_w'(MAX_HOLD - 1);

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [1:0]         r_gnt_id;
    logic [1:0]         r_last_id;
    logic [c_cnt_w-1:0] r_hold;
    logic [2:0]         w_pick;
    logic               w_hold_lim;
    logic               w_release;
    logic               w_gnt_valid;
    logic               w_timeout;

    assign w_pick     = rr_pick(req, r_last_id);
    assign w_hold_lim = (r_hold == c_hold_last);
    assign w_release  = done || !req[r_gnt_id] || w_hold_lim;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  if (w_pick[2]) w_state_nxt = c_st_grant;
            c_st_grant: if (w_release) w_state_nxt = c_st_idle;
            default:    w_state_nxt = c_st_idle;
        endcase
    end

    // timeout flags the hold-limit release in the same cycle it happens,
    // so a simultaneous done or request drop can suppress it.
    always_comb begin
        w_gnt_valid = (r_state == c_st_grant);
        w_timeout   = w_gnt_valid && w_hold_lim && !done && req[r_gnt_id];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt_id  <= 2'd3;
            r_last_id <= 2'd3;
            r_hold    <= '0;
        end else if (r_state == c_st_idle) begin
            if (w_pick[2]) begin
                r_gnt_id <= w_pick[1:0];
                r_hold   <= '0;
            end
        end else if (w_release) begin
            r_last_id <= r_gnt_id;
        end else if (r_hold != {c_cnt_w{1'b1}}) begin
            r_hold <= r_hold + 1'b1;
        end
    end

    decoder u_dec (
        .i_sel (r_gnt_id),
        .i_en  (w_gnt_valid),
        .o_dec (gnt)
    );

    assign gnt_valid = w_gnt_valid;
    assign gnt_id    = r_gnt_id;
    assign timeout   = w_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter4.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_rr_arbiter4: scoreboard bench for rr_arbiter4                   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_rr_arbiter4;

    localparam int c_mh = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic [1:0] gnt_id;
    logic       timeout;

    always #5 clk = ~clk;

    rr_arbiter4 #(.MAX_HOLD(c_mh)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .timeout   (timeout)
    );

    typedef struct {
        logic [3:0] gnt;
        logic       valid;
        logic [1:0] id;
        logic       to;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    bit         m_grant;
    logic [1:0] m_id;
    logic [1:0] m_last;
    int         m_hold;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function void model_reset();
        m_grant = 1'b0;
        m_id    = 2'd3;
        m_last  = 2'd3;
        m_hold  = 0;
    endfunction

    function exp_t model_out(input logic [3:0] r, input logic d);
        exp_t e;
        e.gnt   = m_grant ? (4'b0001 << m_id) : 4'b0000;
        e.valid = m_grant;
        e.id    = m_id;
        e.to    = m_grant && (m_hold == c_mh - 1) && !d && r[m_id];
        return e;
    endfunction

    function void model_step(input logic [3:0] r, input logic d);
        logic [1:0] idx;
        bit         found;
        if (!m_grant) begin
            found = 1'b0;
            for (int k = 1; k <= 4; k++) begin
                idx = m_last + 2'(k);
                if (!found && r[idx]) begin
                    found = 1'b1;
                    m_id  = idx;
                end
            end
            if (found) begin
                m_grant = 1'b1;
                m_hold  = 0;
            end
        end else if (d || !r[m_id] || m_hold == c_mh - 1) begin
            m_grant = 1'b0;
            m_last  = m_id;
        end else begin
            m_hold++;
        end
    endfunction

    task automatic step(input logic [3:0] r, input logic d,
                        output logic [3:0] g_obs, output logic to_obs);
        exp_t e;
        exp_t o;
        @(negedge clk);
        req  = r;
        done = d;
        e = model_out(r, d);
        sb.push_back(e);
        #1;
        o = sb.pop_front();
        check("gnt", gnt, o.gnt);
        check("gnt_valid", gnt_valid, o.valid);
        check("gnt_id", gnt_id, o.id);
        check("timeout", timeout, o.to);
        check("onehot_valid", ($onehot0(gnt) && (gnt_valid == (gnt != 4'b0000))), 1);
        g_obs  = gnt;
        to_obs = timeout;
        model_step(r, d);
    endtask

    task automatic async_reset();
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        #1;
        check("rst_gnt", gnt, 4'b0000);
        check("rst_valid", gnt_valid, 1'b0);
        check("rst_id", gnt_id, 2'd3);
        check("rst_timeout", timeout, 1'b0);
        model_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] g;
        logic       t;
        logic [3:0] seq[$];
        logic [3:0] exp_seq[5];
        logic [3:0] prev;
        int         run;
        bit         ended;
        logic       last_to;

        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        model_reset();
        #12;
        check("reset_gnt", gnt, 4'b0000);
        check("reset_valid", gnt_valid, 1'b0);
        check("reset_id", gnt_id, 2'd3);
        check("reset_timeout", timeout, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full rotation with done every grant.
        prev = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            step(4'b1111, 1'b1, g, t);
            if (g != 4'b0000) begin
                check("bubble_before_grant", prev, 4'b0000);
                seq.push_back(g);
            end
            prev = g;
        end
        check("rotation_len", seq.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < seq.size()) check("rotation_seq", seq[i], exp_seq[i]);
        end
        step(4'b0000, 1'b0, g, t);

        // Hold limit: single requester never releases.
        run     = 0;
        ended   = 1'b0;
        last_to = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(4'b0100, 1'b0, g, t);
            if (!ended) begin
                if (g == 4'b0100) begin
                    run++;
                    last_to = t;
                end else if (run > 0) begin
                    ended = 1'b1;
                    check("hold_len", run, c_mh);
                    check("hold_timeout", last_to, 1'b1);
                end
            end
        end
        check("hold_ended", ended, 1'b1);
        step(4'b0000, 1'b0, g, t);
        step(4'b0000, 1'b0, g, t);

        // Holder 2 drops its request in its third grant cycle.
        step(4'b0100, 1'b0, g, t);
        step(4'b0100, 1'b0, g, t);
        step(4'b0100, 1'b0, g, t);
        step(4'b0000, 1'b0, g, t);
        step(4'b0000, 1'b0, g, t);
        check("drop_gnt", g, 4'b0000);
        check("drop_id", gnt_id, 2'd2);
        check("drop_timeout", t, 1'b0);

        // Holder 1 with done while req changes; wrap to requester 0.
        step(4'b0010, 1'b0, g, t);
        step(4'b0011, 1'b1, g, t);
        check("wrap_holder", g, 4'b0010);
        check("wrap_no_timeout", t, 1'b0);
        step(4'b0011, 1'b0, g, t);
        check("wrap_bubble", g, 4'b0000);
        step(4'b0011, 1'b0, g, t);
        check("wrap_grant", g, 4'b0001);
        step(4'b0000, 1'b1, g, t);

        // Asynchronous reset while requester 3 holds.
        step(4'b1000, 1'b0, g, t);
        step(4'b1000, 1'b0, g, t);
        check("pre_reset_gnt", g, 4'b1000);
        async_reset();
        step(4'b1010, 1'b0, g, t);
        step(4'b1010, 1'b0, g, t);
        check("post_reset_gnt", g, 4'b0010);
        step(4'b0000, 1'b0, g, t);

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            step(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), g, t);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
